// File: rtl/slice_line_merge_if.sv
// slice_line_merge_if: per-slice write side and merged
// raster output stream of slice_line_merge.
interface slice_line_merge_if #(
  parameter int MAX_NBR_SLICES = 8,
  parameter int PIX_PER_BEAT   = 4,
  parameter int BPC            = 14
);
  localparam int DW = PIX_PER_BEAT * 3 * BPC;

  logic [MAX_NBR_SLICES*DW-1:0] in_data;
  logic [MAX_NBR_SLICES-1:0]    in_valid;
  logic [MAX_NBR_SLICES-1:0]    in_sof;
  logic [MAX_NBR_SLICES-1:0]    in_almost_full;
  logic [MAX_NBR_SLICES-1:0]    overflow;
  logic [DW-1:0]                out_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [PIX_PER_BEAT-1:0]      out_mask;
  logic                         out_sof;
  logic                         out_eol;
  logic                         out_eof;

  modport master (
    output in_data, in_valid, in_sof, out_ready,
    input  in_almost_full, overflow,
    input  out_data, out_valid, out_mask,
    input  out_sof, out_eol, out_eof
  );

  modport slave (
    input  in_data, in_valid, in_sof, out_ready,
    output in_almost_full, overflow,
    output out_data, out_valid, out_mask,
    output out_sof, out_eol, out_eof
  );
endinterface

// File: rtl/slice_line_merge.sv
// slice_line_merge: per-slice FWFT FIFOs merged slice by
// slice into one raster stream with ready/valid output.
module slice_line_merge #(
  parameter int MAX_NBR_SLICES  = 8,
  parameter int PIX_PER_BEAT    = 4,
  parameter int BPC             = 14,
  parameter int MAX_SLICE_WIDTH = 2560,
  parameter int FIFO_DEPTH      = 64,
  parameter int AF_MARGIN       = 8
) (
  input  logic clk_core,
  input  logic rst_n,
  input  logic flush,
  input  logic [$clog2(MAX_NBR_SLICES):0] slices_per_line,
  input  logic [$clog2(MAX_SLICE_WIDTH+1)-1:0] slice_width,
  input  logic [15:0] frame_height,
  slice_line_merge_if.slave bus
);
  localparam int DW   = PIX_PER_BEAT * 3 * BPC;
  localparam int NS   = MAX_NBR_SLICES;
  localparam int SPW  = $clog2(NS) + 1;
  localparam int SELW = (NS > 1) ? $clog2(NS) : 1;
  localparam int WW   = $clog2(MAX_SLICE_WIDTH + 1);
  localparam int PL   = $clog2(PIX_PER_BEAT);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_e;

  logic [DW:0]     mem_q [NS][FIFO_DEPTH];
  logic [AW-1:0]   wp_q  [NS];
  logic [AW-1:0]   rp_q  [NS];
  logic [LW-1:0]   lvl_q [NS];
  logic [LW-1:0]   lvl_d [NS];
  logic [DW-1:0]   hdata [NS];
  logic [NS-1:0]   empty, hsof, push, pop;
  logic [NS-1:0]   af_q, af_d, ovf_q, ovf_d;

  logic [SPW-1:0]  nsl;
  logic [SELW-1:0] last_sel;
  logic [WW:0]     wsum;
  logic [WW-1:0]   last_beat;
  logic [PL-1:0]   wrem;
  logic [PIX_PER_BEAT-1:0] lmask;

  state_e          st_q, st_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [WW-1:0]   beat_q, beat_d;
  logic [15:0]     line_q, line_d;
  logic            ov_q, ov_d;
  logic [DW-1:0]   od_q, od_d;
  logic [PIX_PER_BEAT-1:0] om_q, om_d;
  logic            os_q, os_d, oe_q, oe_d, of_q, of_d;
  logic            slot_free, all_sof;
  logic            lastb, lasts, lastl;

  // Clamp the active slice count into 1..NS.
  always_comb begin
    nsl = slices_per_line;
    if (slices_per_line == '0)
      nsl = SPW'(1);
    else if (slices_per_line > SPW'(NS))
      nsl = SPW'(NS);
  end

  assign last_sel  = SELW'(nsl - SPW'(1));
  assign wsum      = {1'b0, slice_width} + (WW+1)'(PIX_PER_BEAT - 1);
  assign last_beat = WW'((wsum >> PL) - (WW+1)'(1));
  assign wrem      = slice_width[PL-1:0];

  // Mask of the final beat of a chunk: a zero remainder is a full beat.
  always_comb begin
    lmask = '0;
    for (int p = 0; p < PIX_PER_BEAT; p++)
      lmask[p] = (wrem == '0) || (PL'(p) < wrem);
  end

  // FWFT head view of every slice FIFO.
  always_comb begin
    for (int s = 0; s < NS; s++) begin
      empty[s] = (lvl_q[s] == '0);
      {hsof[s], hdata[s]} = mem_q[s][rp_q[s]];
    end
  end

  // Merge FSM: stale drain in IDLE, ordered slice readout in STREAM.
  always_comb begin
    st_d      = st_q;
    sel_d     = sel_q;
    beat_d    = beat_q;
    line_d    = line_q;
    ov_d      = ov_q & ~bus.out_ready;
    od_d      = od_q;
    om_d      = om_q;
    os_d      = os_q;
    oe_d      = oe_q;
    of_d      = of_q;
    pop       = '0;
    all_sof   = 1'b1;
    slot_free = ~ov_q | bus.out_ready;
    lastb     = (beat_q == last_beat);
    lasts     = (sel_q == last_sel);
    lastl     = (line_q == frame_height - 16'd1);
    unique case (st_q)
      IDLE: begin
        for (int s = 0; s < NS; s++) begin
          if (SPW'(s) < nsl) begin
            if (empty[s] || !hsof[s])
              all_sof = 1'b0;
            if (!empty[s] && !hsof[s])
              pop[s] = 1'b1;
          end
        end
        if (all_sof) begin
          st_d   = STREAM;
          sel_d  = '0;
          beat_d = '0;
          line_d = '0;
        end
      end
      STREAM: begin
        if (!empty[sel_q] && slot_free) begin
          pop[sel_q] = 1'b1;
          ov_d = 1'b1;
          od_d = hdata[sel_q];
          om_d = lastb ? lmask : '1;
          os_d = (sel_q == '0) && (beat_q == '0)
                 && (line_q == '0);
          oe_d = lastb && lasts;
          of_d = lastb && lasts && lastl;
          beat_d = lastb ? '0 : beat_q + WW'(1);
          if (lastb) begin
            if (lasts) begin
              sel_d  = '0;
              line_d = line_q + 16'd1;
              if (lastl)
                st_d = IDLE;
            end else begin
              sel_d = sel_q + SELW'(1);
            end
          end
        end
      end
      default: st_d = IDLE;
    endcase
  end

  // Write acceptance, overflow and level update per slice.
  always_comb begin
    for (int s = 0; s < NS; s++) begin
      push[s]  = bus.in_valid[s] & ~flush
                 & ((lvl_q[s] != LW'(FIFO_DEPTH)) | pop[s]);
      ovf_d[s] = ovf_q[s]
                 | (bus.in_valid[s] & ~flush & ~push[s]);
      lvl_d[s] = lvl_q[s] + LW'(push[s]) - LW'(pop[s]);
      af_d[s]  = lvl_d[s] >= LW'(FIFO_DEPTH - AF_MARGIN);
    end
  end

  // FIFO storage; contents need no reset, pointers gate them.
  always_ff @(posedge clk_core) begin
    for (int s = 0; s < NS; s++)
      if (push[s])
        mem_q[s][wp_q[s]] <= {bus.in_sof[s],
                              bus.in_data[s*DW +: DW]};
  end

  // FIFO pointers, levels and status flags.
  always_ff @(posedge clk_core or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NS; s++) begin
        wp_q[s]  <= '0;
        rp_q[s]  <= '0;
        lvl_q[s] <= '0;
      end
      af_q  <= '0;
      ovf_q <= '0;
    end else if (flush) begin
      for (int s = 0; s < NS; s++) begin
        wp_q[s]  <= '0;
        rp_q[s]  <= '0;
        lvl_q[s] <= '0;
      end
      af_q  <= '0;
      ovf_q <= '0;
    end else begin
      for (int s = 0; s < NS; s++) begin
        if (push[s]) wp_q[s] <= wp_q[s] + AW'(1);
        if (pop[s])  rp_q[s] <= rp_q[s] + AW'(1);
        lvl_q[s] <= lvl_d[s];
      end
      af_q  <= af_d;
      ovf_q <= ovf_d;
    end
  end

  // FSM state, counters and output register.
  always_ff @(posedge clk_core or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= IDLE;
      sel_q  <= '0;
      beat_q <= '0;
      line_q <= '0;
      ov_q   <= 1'b0;
      od_q   <= '0;
      om_q   <= '0;
      os_q   <= 1'b0;
      oe_q   <= 1'b0;
      of_q   <= 1'b0;
    end else if (flush) begin
      st_q   <= IDLE;
      sel_q  <= '0;
      beat_q <= '0;
      line_q <= '0;
      ov_q   <= 1'b0;
      od_q   <= '0;
      om_q   <= '0;
      os_q   <= 1'b0;
      oe_q   <= 1'b0;
      of_q   <= 1'b0;
    end else begin
      st_q   <= st_d;
      sel_q  <= sel_d;
      beat_q <= beat_d;
      line_q <= line_d;
      ov_q   <= ov_d;
      od_q   <= od_d;
      om_q   <= om_d;
      os_q   <= os_d;
      oe_q   <= oe_d;
      of_q   <= of_d;
    end
  end

  assign bus.in_almost_full = af_q;
  assign bus.overflow       = ovf_q;
  assign bus.out_valid      = ov_q;
  assign bus.out_data       = od_q;
  assign bus.out_mask       = om_q;
  assign bus.out_sof        = os_q;
  assign bus.out_eol        = oe_q;
  assign bus.out_eof        = of_q;
endmodule

// File: tb/tb_slice_line_merge.sv
// tb_slice_line_merge: random frames against a raster
// reference model, scoreboard checked by an output monitor.
module tb_slice_line_merge;
  localparam int NS  = 8;
  localparam int PPB = 4;
  localparam int BPC = 14;
  localparam int DW  = PPB * 3 * BPC;
  localparam int CW  = DW + 8;
  localparam int BIG = 1 << 30;

  typedef struct {
    logic [DW-1:0]  d;
    logic [PPB-1:0] m;
    logic           sof, eol, eof;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic [3:0]  spl = 4'd1;
  logic [11:0] sw = 12'd16;
  logic [15:0] fh = 16'd1;

  exp_t        expq[$];
  logic [DW:0] pend[NS][$];
  int          npass = 0;
  int          ntot = 0;
  int          rdy_mode = 1;

  always #5 clk = ~clk;

  slice_line_merge_if #(.MAX_NBR_SLICES(NS),
    .PIX_PER_BEAT(PPB), .BPC(BPC)) bif ();

  slice_line_merge #(
    .MAX_NBR_SLICES(NS), .PIX_PER_BEAT(PPB), .BPC(BPC),
    .MAX_SLICE_WIDTH(2560), .FIFO_DEPTH(64), .AF_MARGIN(8)
  ) dut (
    .clk_core(clk),
    .rst_n(rst_n),
    .flush(flush),
    .slices_per_line(spl),
    .slice_width(sw),
    .frame_height(fh),
    .bus(bif.slave)
  );

  task automatic chk(input string nm,
                     input logic [CW-1:0] act,
                     input logic [CW-1:0] req);
    ntot++;
    if (act === req) npass++;
    else $display("FAIL %s: got %h expected %h", nm, act, req);
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < 6; i++)
      r = (r << 32) | DW'($urandom);
    return r;
  endfunction

  // Sink readiness: 0 never, 1 always, 2 about 30 percent.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bif.out_ready = 1'b0;
      1:       bif.out_ready = 1'b1;
      default: bif.out_ready = ($urandom_range(99) < 30);
    endcase
  end

  // Output monitor: compare accepted beats, check hold on stall.
  logic            stall_seen = 1'b0;
  logic [CW-1:0]   held;
  always @(negedge clk) begin
    logic [CW-1:0] cur;
    exp_t e;
    cur = CW'({bif.out_mask, bif.out_sof, bif.out_eol,
               bif.out_eof, bif.out_data});
    if (!rst_n) begin
      stall_seen = 1'b0;
    end else begin
      if (stall_seen && bif.out_valid)
        chk("stall hold", cur, held);
      if (bif.out_valid && bif.out_ready) begin
        if (expq.size() == 0) begin
          ntot++;
          $display("FAIL extra beat: got %h expected none", cur);
        end else begin
          e = expq.pop_front();
          chk("beat data", CW'(bif.out_data), CW'(e.d));
          chk("beat flags",
              CW'({bif.out_mask, bif.out_sof,
                   bif.out_eol, bif.out_eof}),
              CW'({e.m, e.sof, e.eol, e.eof}));
        end
      end
      stall_seen = bif.out_valid & ~bif.out_ready;
      held = cur;
    end
  end

  // Reference model: one frame as raster order of slice chunks.
  task automatic gen_frame(input int spl_v, input int w,
                           input int h);
    int ns;
    int cb;
    int lp;
    logic [DW-1:0] d;
    logic [DW-1:0] fr[NS][$];
    exp_t e;
    ns = (spl_v == 0) ? 1 : ((spl_v > NS) ? NS : spl_v);
    cb = (w + PPB - 1) / PPB;
    lp = (w % PPB == 0) ? PPB : (w % PPB);
    spl = 4'(spl_v);
    sw  = 12'(w);
    fh  = 16'(h);
    for (int s = 0; s < ns; s++)
      for (int i = 0; i < cb * h; i++) begin
        d = rnd();
        fr[s].push_back(d);
        pend[s].push_back({(i == 0) ? 1'b1 : 1'b0, d});
      end
    for (int l = 0; l < h; l++)
      for (int s = 0; s < ns; s++)
        for (int b = 0; b < cb; b++) begin
          e.d   = fr[s][l*cb + b];
          e.m   = (b == cb - 1) ? PPB'((1 << lp) - 1) : '1;
          e.sof = (l == 0) && (s == 0) && (b == 0);
          e.eol = (s == ns - 1) && (b == cb - 1);
          e.eof = e.eol && (l == h - 1);
          expq.push_back(e);
        end
  endtask

  task automatic write_pending(input int maxw);
    int nw;
    int cyc;
    bit busy;
    logic [DW:0] x;
    nw = 0;
    cyc = 0;
    busy = 1'b1;
    while (busy && nw < maxw && cyc < 20000) begin
      @(posedge clk); #1;
      bif.in_valid = '0;
      bif.in_sof = '0;
      busy = 1'b0;
      for (int s = 0; s < NS; s++)
        if (pend[s].size() > 0) begin
          busy = 1'b1;
          if (!bif.in_almost_full[s] && nw < maxw
              && $urandom_range(3) != 0) begin
            x = pend[s].pop_front();
            bif.in_valid[s] = 1'b1;
            bif.in_sof[s] = x[DW];
            bif.in_data[s*DW +: DW] = x[DW-1:0];
            nw++;
          end
        end
      cyc++;
    end
    @(posedge clk); #1;
    bif.in_valid = '0;
    bif.in_sof = '0;
    if (cyc >= 20000) begin
      ntot++;
      $display("FAIL write timeout: got %0d cycles expected <20000",
               cyc);
    end
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while (expq.size() != 0 && c < 5000) begin
      @(posedge clk);
      c++;
    end
    ntot++;
    if (expq.size() == 0) npass++;
    else $display("FAIL drain: got %0d beats pending expected 0",
                  expq.size());
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int s, input int w, input int h);
    gen_frame(s, w, h);
    write_pending(BIG);
    wait_drain();
  endtask

  task automatic clear_model();
    expq.delete();
    for (int s = 0; s < NS; s++) pend[s].delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [DW:0] tmp[$];
    int c;
    bif.in_valid = '0;
    bif.in_sof = '0;
    bif.in_data = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset valid", CW'(bif.out_valid), '0);
    chk("reset data", CW'(bif.out_data), '0);
    chk("reset flags", CW'({bif.out_mask, bif.out_sof,
        bif.out_eol, bif.out_eof}), '0);
    chk("reset af", CW'(bif.in_almost_full), '0);
    chk("reset ovf", CW'(bif.overflow), '0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    rdy_mode = 1;
    run_frame(2, 16, 2);
    run_frame(1, 14, 1);
    rdy_mode = 2;
    run_frame(2, 16, 2);

    // Fill slice 0 while slice 1 withholds its sof.
    rdy_mode = 0;
    gen_frame(2, 16, 16);
    tmp = pend[1];
    pend[1].delete();
    for (int k = 1; k <= 65; k++) begin
      @(posedge clk); #1;
      if (k > 1) begin
        chk("af level", CW'(bif.in_almost_full[0]),
            CW'(k - 1 >= 56));
        chk("ovf before full", CW'(bif.overflow), '0);
      end
      bif.in_valid[0] = 1'b1;
      if (k <= 64) begin
        {bif.in_sof[0], bif.in_data[0 +: DW]} =
          pend[0].pop_front();
      end else begin
        bif.in_sof[0] = 1'b0;
        bif.in_data[0 +: DW] = rnd();
      end
    end
    @(posedge clk); #1;
    bif.in_valid = '0;
    bif.in_sof = '0;
    chk("af full", CW'(bif.in_almost_full), CW'(8'h01));
    chk("ovf set", CW'(bif.overflow), CW'(8'h01));
    pend[1] = tmp;
    rdy_mode = 1;
    write_pending(BIG);
    wait_drain();
    chk("ovf sticky", CW'(bif.overflow), CW'(8'h01));
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("ovf flushed", CW'(bif.overflow), '0);

    // Stale beats ahead of a frame.
    for (int i = 0; i < 3; i++)
      pend[0].push_back({1'b0, rnd()});
    write_pending(BIG);
    run_frame(2, 16, 2);

    // Flush in the middle of a line.
    gen_frame(2, 16, 2);
    write_pending(12);
    c = 0;
    while (expq.size() > 13 && c < 2000) begin
      @(posedge clk);
      c++;
    end
    chk("pre-flush progress", CW'(expq.size() <= 13), CW'(1));
    rdy_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    flush = 1'b1;
    bif.in_valid[0] = 1'b1;
    bif.in_sof[0] = 1'b1;
    bif.in_data[0 +: DW] = rnd();
    @(posedge clk); #1;
    flush = 1'b0;
    bif.in_valid = '0;
    bif.in_sof = '0;
    chk("flush valid", CW'(bif.out_valid), '0);
    chk("flush af", CW'(bif.in_almost_full), '0);
    clear_model();
    rdy_mode = 1;
    run_frame(2, 16, 2);

    // Slice count clamping.
    run_frame(0, 16, 2);
    run_frame(9, 8, 2);

    for (int i = 0; i < 4; i++) begin
      rdy_mode = $urandom_range(1, 2);
      run_frame($urandom_range(0, 9), $urandom_range(1, 40),
                $urandom_range(1, 3));
    end

    // Reset in the middle of a frame.
    rdy_mode = 1;
    gen_frame(2, 16, 2);
    write_pending(10);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset valid", CW'(bif.out_valid), '0);
    chk("midreset af", CW'(bif.in_almost_full), '0);
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_frame(2, 16, 2);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
